// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target (receiver_i2c) and transmitter_I2C.
//   - i2c_state_t : target FSM states
//   - i2c_line_t  : decoded bus events from the line sampler
//   - I2C_* constants for address width, RNW polarity and ACK/NACK levels
//   - maj3()      : 3-sample majority vote used by the optional glitch filter
package i2c_pkg;
  localparam int   I2C_ADDR_W   = 7;
  localparam logic I2C_RNW_READ = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, WR_BYTE, ACK_W, RD_BYTE, MACK, WAIT_P, IGNORE
  } i2c_state_t;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;       // (filtered) current SDA level, used for bit sampling
  } i2c_line_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction
endpackage

// File: rtl/i2c_line_sampler.sv
// i2c_line_sampler: samples SCL/SDA in the clk domain and decodes bus events.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   scl, sda : bus lines (sda already wired-AND resolved)
//   ev       : scl_rise / scl_fall / start / stop pulses plus current sda level
// Macro I2C_RX_GLITCH_FILTER_EN: when defined, each line passes a 3-sample
// majority filter first (2 clk extra latency, 1-clk pulses rejected).
module i2c_line_sampler
  import i2c_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      scl,
  input  logic      sda,
  output i2c_line_t ev
);
  logic scl_f, sda_f;
  logic scl_q, sda_q;

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic [2:0] scl_h, sda_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h <= '1;
      sda_h <= '1;
    end else begin
      scl_h <= {scl_h[1:0], scl};
      sda_h <= {sda_h[1:0], sda};
    end
  end

  assign scl_f = maj3(scl_h);
  assign sda_f = maj3(sda_h);
`else
  assign scl_f = scl;
  assign sda_f = sda;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // START/STOP require SCL high both before and now: an SDA edge that lands
  // on the same clk as an SCL edge is treated as an ordinary data change.
  always_comb begin
    ev.scl_rise = scl_f & ~scl_q;
    ev.scl_fall = ~scl_f & scl_q;
    ev.start    = scl_q & scl_f & sda_q & ~sda_f;
    ev.stop     = scl_q & scl_f & ~sda_q & sda_f;
    ev.sda      = sda_f;
  end
endmodule

// File: rtl/receiver_i2c.sv
// receiver_i2c: I2C target matching a 7-bit address, accepting DATA_W-bit
// writes and returning DATA_W-bit reads (MSB first, NBYTES = DATA_W/8).
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   MY_ADDR          : own address (static while BUSY)
//   SCL, SDA_OUT/OE  : master bus clock, SDA drive value and drive enable
//   RD_DATA          : read word, captured at the end of the address ACK
//   SDA_IN           : target SDA drive (1 = released)
//   WR_DATA, WR_STB  : last complete write word and its 1-clk update strobe
//   BUSY             : START..STOP
//   NACK_ERR         : sticky early-NACK flag on reads, cleared by START
// Macro I2C_RX_GLITCH_FILTER_EN enables the majority filter in the sampler.
module receiver_i2c
  import i2c_pkg::*;
#(
  parameter int ADDR_W = I2C_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] MY_ADDR,
  input  logic              SCL,
  input  logic              SDA_OUT,
  input  logic              SDA_OE,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              SDA_IN,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_STB,
  output logic              BUSY,
  output logic              NACK_ERR
);
  localparam int NBYTES = DATA_W / 8;
  localparam int BC_W   = $clog2(NBYTES) + 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NBYTES - 1);

  logic              sda_line;
  i2c_line_t         ln;
  i2c_state_t        state;
  logic [2:0]        bit_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic              phase;   // ACK states: 0 = await first fall, 1 = driving
  logic              rnw;
  logic [ADDR_W-1:0] a_sh;
  logic [DATA_W-1:0] wr_sh;
  logic [DATA_W-1:0] rd_sh;

  // Wired-AND bus: our own drive is part of what we sample.
  assign sda_line = (SDA_OE ? SDA_OUT : 1'b1) & SDA_IN;

  i2c_line_sampler u_ls (
    .clk (clk),
    .rst (rst),
    .scl (SCL),
    .sda (sda_line),
    .ev  (ln)
  );

  // Bits are taken on scl_rise, SDA_IN only moves on scl_fall, so the
  // target's drive is stable across every SCL high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      SDA_IN   <= 1'b1;
      WR_DATA  <= '0;
      WR_STB   <= 1'b0;
      BUSY     <= 1'b0;
      NACK_ERR <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      phase    <= 1'b0;
      rnw      <= 1'b0;
      a_sh     <= '0;
      wr_sh    <= '0;
      rd_sh    <= '0;
    end else begin
      WR_STB <= 1'b0;
      if (ln.start) begin
        state    <= ADDR;
        SDA_IN   <= 1'b1;
        BUSY     <= 1'b1;
        NACK_ERR <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        phase    <= 1'b0;
      end else if (ln.stop) begin
        state    <= IDLE;
        SDA_IN   <= 1'b1;
        BUSY     <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        phase    <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: if (ln.scl_rise) begin
            a_sh    <= {a_sh[ADDR_W-2:0], ln.sda};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // a_sh already holds the 7 address bits; this bit is RNW
              rnw   <= ln.sda;
              phase <= 1'b0;
              state <= (a_sh == MY_ADDR) ? ACK_A : IGNORE;
            end
          end
          ACK_A: if (ln.scl_fall) begin
            if (!phase) begin
              SDA_IN <= I2C_ACK;
              phase  <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (rnw == I2C_RNW_READ) begin
                // first read bit goes out on the fall that ends the ACK
                SDA_IN <= RD_DATA[DATA_W-1];
                rd_sh  <= {RD_DATA[DATA_W-2:0], 1'b0};
                state  <= RD_BYTE;
              end else begin
                SDA_IN <= 1'b1;
                state  <= WR_BYTE;
              end
            end
          end
          WR_BYTE: if (ln.scl_rise) begin
            wr_sh   <= {wr_sh[DATA_W-2:0], ln.sda};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              phase <= 1'b0;
              state <= ACK_W;
            end
          end
          ACK_W: if (ln.scl_fall) begin
            if (!phase) begin
              SDA_IN <= I2C_ACK;
              phase  <= 1'b1;
            end else begin
              SDA_IN <= 1'b1;
              phase  <= 1'b0;
              if (byte_cnt == LAST_BYTE) begin
                WR_DATA <= wr_sh;
                WR_STB  <= 1'b1;
                state   <= WAIT_P;
              end else begin
                byte_cnt <= byte_cnt + BC_W'(1);
                state    <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (ln.scl_fall) begin
              SDA_IN <= rd_sh[DATA_W-1];
              rd_sh  <= {rd_sh[DATA_W-2:0], 1'b0};
            end
            if (ln.scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                phase <= 1'b0;
                state <= MACK;
              end
            end
          end
          MACK: begin
            if (ln.scl_fall && !phase) begin
              SDA_IN <= 1'b1;
              phase  <= 1'b1;
            end else if (ln.scl_rise && phase) begin
              phase <= 1'b0;
              if (ln.sda == I2C_ACK && byte_cnt != LAST_BYTE) begin
                // next byte's MSB is driven by RD_BYTE on the coming fall
                byte_cnt <= byte_cnt + BC_W'(1);
                state    <= RD_BYTE;
              end else begin
                if (ln.sda == I2C_NACK && byte_cnt != LAST_BYTE)
                  NACK_ERR <= 1'b1;
                state <= WAIT_P;
              end
            end
          end
          WAIT_P, IGNORE: SDA_IN <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_receiver_i2c.sv
`timescale 1ns/1ps
module tb_receiver_i2c;
  import i2c_pkg::*;

`ifdef I2C_RX_GLITCH_FILTER_EN
  localparam int HP = 4;   // SCL half period in clk
`else
  localparam int HP = 2;
`endif
  localparam int SU = HP / 2; // master data setup point inside SCL low

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  my_addr = 7'h2A;
  logic        scl = 1'b1, sda_out = 1'b1, sda_oe = 1'b0;
  logic [15:0] rd_data = '0;
  logic        sda_in, wr_stb, busy, nack_err;
  logic [15:0] wr_data;

  receiver_i2c dut (
    .clk(clk), .rst(rst), .MY_ADDR(my_addr), .SCL(scl), .SDA_OUT(sda_out),
    .SDA_OE(sda_oe), .RD_DATA(rd_data), .SDA_IN(sda_in), .WR_DATA(wr_data),
    .WR_STB(wr_stb), .BUSY(busy), .NACK_ERR(nack_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int stb_cnt = 0;
  // reference model state
  logic [15:0] exp_wr = '0;
  int          exp_stb = 0;
  logic        exp_nack = 1'b0;

  always @(negedge clk) if (wr_stb) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // (Repeated) START: release SDA during SCL low, raise SCL, pull SDA low.
  task automatic start_c();
    scl = 1'b0; tick(SU);
    sda_oe = 1'b0; tick(HP - SU);
    scl = 1'b1; tick(HP);
    sda_oe = 1'b1; sda_out = 1'b0; tick(HP);
  endtask

  task automatic stop_c();
    scl = 1'b0; tick(SU);
    sda_oe = 1'b1; sda_out = 1'b0; tick(HP - SU);
    scl = 1'b1; tick(HP);
    sda_oe = 1'b0; tick(2 * HP);
  endtask

  // One SCL bit slot; seen = target drive in the middle of SCL high.
  // g inserts a 1-clk SCL pulse in the low phase (filter build only).
  task automatic slot(input bit drv, input bit val, input bit g, output bit seen);
    scl = 1'b0; tick(SU);
    sda_oe = drv; sda_out = val;
    if (g) begin tick(1); scl = 1'b1; tick(1); scl = 1'b0; end
    tick(HP - SU);
    scl = 1'b1; tick(SU);
    seen = sda_in;
    tick(HP - SU);
  endtask

  task automatic wr_xfer(input logic [6:0] a, input logic [15:0] d, input int nbits,
                         input bit glitch, input int pre_rs);
    bit s;
    int drv_err = 0;
    bit match = (a == my_addr);
    logic [7:0] ab = {a, 1'b0};
    if (pre_rs > 0) begin
      // aborted transfer, then a repeated START mid-byte
      start_c();
      for (int i = 7; i >= 0; i--) slot(1'b1, ab[i], 1'b0, s);
      slot(1'b0, 1'b1, 1'b0, s);
      for (int i = 0; i < pre_rs; i++) slot(1'b1, ~d[15-i], 1'b0, s);
    end
    start_c();
    for (int i = 7; i >= 0; i--) begin slot(1'b1, ab[i], 1'b0, s); if (!s) drv_err++; end
    slot(1'b0, 1'b1, 1'b0, s);
    chk("wr_addr_ack", 32'(s), 32'(match ? I2C_ACK : I2C_NACK));
    chk("busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      slot(1'b1, d[15-i], glitch && (i == 3), s);
      if (!s) drv_err++;
      if (i % 8 == 7) begin
        slot(1'b0, 1'b1, 1'b0, s);
        chk("wr_data_ack", 32'(s), 32'(match ? I2C_ACK : I2C_NACK));
      end
    end
    stop_c();
    exp_nack = 1'b0;
    if (match && nbits == 16) begin exp_wr = d; exp_stb++; end
    chk("wr_released", 32'(drv_err), 32'd0);
    chk("wr_data", 32'(wr_data), 32'(exp_wr));
    chk("wr_stb_cnt", 32'(stb_cnt), 32'(exp_stb));
    chk("busy_off", 32'(busy), 32'd0);
    chk("nack_err_w", 32'(nack_err), 32'(exp_nack));
  endtask

  // nb bytes read; the last one is NACKed unless last_ack (only with nb==2).
  task automatic rd_xfer(input logic [6:0] a, input int nb, input bit last_ack);
    bit s;
    int drv_err = 0;
    bit match = (a == my_addr);
    logic [7:0] ab = {a, I2C_RNW_READ};
    logic [7:0] got, exp;
    start_c();
    for (int i = 7; i >= 0; i--) begin slot(1'b1, ab[i], 1'b0, s); if (!s) drv_err++; end
    slot(1'b0, 1'b1, 1'b0, s);
    chk("rd_addr_ack", 32'(s), 32'(match ? I2C_ACK : I2C_NACK));
    for (int k = 0; k < nb; k++) begin
      for (int i = 7; i >= 0; i--) begin slot(1'b0, 1'b1, 1'b0, s); got[i] = s; end
      exp = !match ? 8'hFF : (k == 0 ? rd_data[15:8] : rd_data[7:0]);
      chk("rd_byte", 32'(got), 32'(exp));
      slot(1'b1, (k == nb - 1 && !last_ack) ? I2C_NACK : I2C_ACK, 1'b0, s);
      if (!s) drv_err++;
    end
    if (last_ack) begin
      slot(1'b0, 1'b1, 1'b0, s);
      chk("rd_no_extra", 32'(s), 32'd1);
    end
    stop_c();
    exp_nack = match && nb == 1 && !last_ack;
    chk("rd_released", 32'(drv_err), 32'd0);
    chk("nack_err_r", 32'(nack_err), 32'(exp_nack));
    chk("rd_wr_stb_cnt", 32'(stb_cnt), 32'(exp_stb));
    chk("busy_off_r", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    tick(3);
    chk("rst_sda", 32'(sda_in), 32'd1);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_stb", 32'(wr_stb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack", 32'(nack_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // directed cases
    wr_xfer(7'h2A, 16'hA55A, 16, 1'b0, 0);
    rd_data = 16'h1234;
    rd_xfer(7'h2A, 2, 1'b0);
    wr_xfer(7'h2B, 16'h0F0F, 16, 1'b0, 0);
    wr_xfer(7'h2A, 16'hDEAD, 12, 1'b0, 0);
    wr_xfer(7'h2A, 16'h00FF, 16, 1'b0, 0);
    wr_xfer(7'h2A, 16'hBEEF, 16, 1'b0, 5);
    rd_data = 16'hC3A5;
    rd_xfer(7'h2A, 2, 1'b1);
    rd_xfer(7'h2A, 1, 1'b0);

    // START clears the sticky NACK error
    start_c(); tick(2);
    chk("nack_clr", 32'(nack_err), 32'd0);
    exp_nack = 1'b0;
    stop_c();

    // reset in the middle of a read while the target pulls SDA low
    rd_data = 16'h0F0F;
    start_c();
    for (int i = 7; i >= 0; i--) slot(1'b1, (i == 0) ? 1'b1 : my_addr[i-1], 1'b0, s);
    slot(1'b0, 1'b1, 1'b0, s);
    scl = 1'b0; tick(HP);
    chk("rd_drive_low", 32'(sda_in), 32'd0);
    rst = 1'b1; tick(1);
    chk("rst_mid_sda", 32'(sda_in), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    exp_wr = '0;
    scl = 1'b1; tick(HP);
    stop_c();
    chk("rst_mid_wr", 32'(wr_data), 32'(exp_wr));

`ifdef I2C_RX_GLITCH_FILTER_EN
    wr_xfer(7'h2A, 16'h5AA5, 16, 1'b1, 0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 24; n++) begin
      logic [6:0] a;
      my_addr = 7'($urandom);
      a = ($urandom_range(0, 3) == 0) ? (my_addr ^ 7'($urandom_range(1, 127))) : my_addr;
      if ($urandom_range(0, 1) == 0) begin
        wr_xfer(a, 16'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16,
                1'b0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0);
      end else begin
        int nb;
        rd_data = 16'($urandom);
        nb = int'($urandom_range(1, 2));
        rd_xfer(a, nb, (nb == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
